// File: rtl/aer_pkg.sv
// Shared types and constants for the AER receive path.
package aer_pkg;

  typedef enum logic [0:0] {
    RX_IDLE   = 1'b0,
    RX_ACK_HI = 1'b1
  } rx_state_e;

  localparam int AER_FIFO_DEPTH_DEFAULT = 4;

  // Address bus width given the MSB index of the pixel address.
  function automatic int aer_addr_width(input int image_size_bits);
    return image_size_bits + 1;
  endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count, full and empty.
module aer_event_fifo #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    head,
  output logic [PTR_BITS:0]   count,
  output logic                full,
  output logic                empty
);

  localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);
  localparam logic [PTR_BITS:0]   CNT_ONE   = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS:0]   CNT_DEPTH = (PTR_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Full comes from the registered count, so a same-cycle pop never admits a push.
  assign full    = (count == CNT_DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; the empty flag masks stale words, and a reset
  // network on every entry would cost flops for no functional gain.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: every sequential assignment is non-blocking so all flops update
  // from pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aer_receiver.sv
// Receive side of the 4-phase AER REQ/ACK link; buffers events for the core.
// Optional AER_RX_ADDR_CHECK_EN: out-of-range addresses are acked, dropped and flagged on ADDR_ERR.
module aer_receiver
  import aer_pkg::*;
#(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int FIFO_DEPTH      = AER_FIFO_DEPTH_DEFAULT,
  parameter int FIFO_PTR_BITS   = $clog2(FIFO_DEPTH)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [IMAGE_SIZE_BITS:0] AERIN_ADDR,
  input  logic                     AERIN_REQ,
  output logic                     AERIN_ACK,
  output logic [IMAGE_SIZE_BITS:0] EVENT_ADDR,
  output logic                     EVENT_VALID,
  input  logic                     EVENT_READY,
  output logic [FIFO_PTR_BITS:0]   FIFO_COUNT,
  output logic                     AERIN_RX_BUSY
`ifdef AER_RX_ADDR_CHECK_EN
  ,
  output logic                     ADDR_ERR
`endif
);

  localparam int ADDR_W = aer_addr_width(IMAGE_SIZE_BITS);

  rx_state_e state;
  rx_state_e state_next;
  logic      req_sync_int;
  logic      req_sync;
  logic      fifo_push;
  logic      fifo_full;
  logic      fifo_empty;
  logic      capture_ok;

`ifdef AER_RX_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] IMAGE_SIZE_A = ADDR_W'(IMAGE_SIZE);
  logic addr_in_range;
  logic capture_err;

  assign addr_in_range = (AERIN_ADDR < IMAGE_SIZE_A);
  // Dropped addresses never touch the FIFO, so backpressure does not hold them off.
  assign capture_ok    = !fifo_full || !addr_in_range;
`else
  assign capture_ok    = !fifo_full;
`endif

  // Two-flop REQ synchroniser; ADDR is sampled raw because it settled long before REQ_sync.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_sync_int <= 1'b0;
      req_sync     <= 1'b0;
    end else begin
      req_sync_int <= AERIN_REQ;
      req_sync     <= req_sync_int;
    end
  end

  // A reset mid-handshake may re-capture a still-high REQ: a duplicate event is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RX_IDLE;
`ifdef AER_RX_ADDR_CHECK_EN
      ADDR_ERR <= 1'b0;
`endif
    end else begin
      state <= state_next;
`ifdef AER_RX_ADDR_CHECK_EN
      ADDR_ERR <= capture_err;
`endif
    end
  end

  // NOTE: each combinational output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      RX_IDLE:   if (req_sync && capture_ok) state_next = RX_ACK_HI;
      RX_ACK_HI: if (!req_sync)              state_next = RX_IDLE;
      default:   state_next = RX_IDLE;
    endcase
  end

  // ACK decodes a single state flop, so it is glitch-free and effectively registered.
  always_comb begin
    AERIN_ACK = 1'b0;
    fifo_push = 1'b0;
`ifdef AER_RX_ADDR_CHECK_EN
    capture_err = 1'b0;
`endif
    unique case (state)
      RX_IDLE: begin
`ifdef AER_RX_ADDR_CHECK_EN
        fifo_push   = req_sync && !fifo_full && addr_in_range;
        capture_err = req_sync && !addr_in_range;
`else
        fifo_push   = req_sync && !fifo_full;
`endif
      end
      RX_ACK_HI: AERIN_ACK = 1'b1;
      default:   AERIN_ACK = 1'b0;
    endcase
    AERIN_RX_BUSY = (state != RX_IDLE) || !fifo_empty;
  end

  aer_event_fifo #(
    .WIDTH    (ADDR_W),
    .DEPTH    (FIFO_DEPTH),
    .PTR_BITS (FIFO_PTR_BITS)
  ) u_event_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (fifo_push),
    .push_data (AERIN_ADDR),
    .pop       (EVENT_READY),
    .head      (EVENT_ADDR),
    .count     (FIFO_COUNT),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign EVENT_VALID = !fifo_empty;

endmodule

// File: tb/tb_aer_receiver.sv
// Directed self-checking bench for aer_receiver.
module tb_aer_receiver;

  localparam int IMAGE_SIZE      = 5;
  localparam int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE);
  localparam int FIFO_DEPTH      = 4;
  localparam int FIFO_PTR_BITS   = $clog2(FIFO_DEPTH);

  typedef logic [IMAGE_SIZE_BITS:0] addr_t;
  typedef logic [FIFO_PTR_BITS:0]   cnt_t;

  logic  CLK = 1'b0;
  logic  RST_N;
  addr_t AERIN_ADDR;
  logic  AERIN_REQ;
  logic  AERIN_ACK;
  addr_t EVENT_ADDR;
  logic  EVENT_VALID;
  logic  EVENT_READY;
  cnt_t  FIFO_COUNT;
  logic  AERIN_RX_BUSY;
`ifdef AER_RX_ADDR_CHECK_EN
  logic  ADDR_ERR;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit    mon_en = 1'b0;
  addr_t mon_q[$];

  aer_receiver #(
    .IMAGE_SIZE      (IMAGE_SIZE),
    .IMAGE_SIZE_BITS (IMAGE_SIZE_BITS),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_PTR_BITS   (FIFO_PTR_BITS)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .AERIN_ADDR    (AERIN_ADDR),
    .AERIN_REQ     (AERIN_REQ),
    .AERIN_ACK     (AERIN_ACK),
    .EVENT_ADDR    (EVENT_ADDR),
    .EVENT_VALID   (EVENT_VALID),
    .EVENT_READY   (EVENT_READY),
    .FIFO_COUNT    (FIFO_COUNT),
    .AERIN_RX_BUSY (AERIN_RX_BUSY)
`ifdef AER_RX_ADDR_CHECK_EN
    ,
    .ADDR_ERR      (ADDR_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  // Records every delivered event; negedge sees the values the next posedge will act on.
  always @(negedge CLK) begin
    if (mon_en && EVENT_VALID && EVENT_READY) mon_q.push_back(EVENT_ADDR);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input logic level, input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      if (AERIN_ACK === level) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic do_event(input addr_t addr, output bit ok);
    bit ok_hi, ok_lo;
    AERIN_ADDR = addr;
    AERIN_REQ  = 1'b1;
    wait_ack(1'b1, 20, ok_hi);
    AERIN_REQ  = 1'b0;
    wait_ack(1'b0, 20, ok_lo);
    ok = ok_hi && ok_lo;
  endtask

  task automatic test_reset();
    RST_N       = 1'b0;
    AERIN_ADDR  = '0;
    AERIN_REQ   = 1'b0;
    EVENT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    tick();
    n_checks++; if (AERIN_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", AERIN_ACK); end
    n_checks++; if (EVENT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", EVENT_VALID); end
    n_checks++; if (EVENT_ADDR !== addr_t'(0)) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", EVENT_ADDR); end
    n_checks++; if (FIFO_COUNT !== cnt_t'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", FIFO_COUNT); end
    n_checks++; if (AERIN_RX_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", AERIN_RX_BUSY); end
  endtask

  task automatic test_single_event();
    AERIN_ADDR = addr_t'(3);
    AERIN_REQ  = 1'b1;
    tick();
    n_checks++; if (AERIN_ACK !== 1'b0) begin n_fail++; $display("FAIL single_ack_k: got %b want 0", AERIN_ACK); end
    tick();
    n_checks++; if (AERIN_ACK !== 1'b0) begin n_fail++; $display("FAIL single_ack_k1: got %b want 0", AERIN_ACK); end
    n_checks++; if (EVENT_VALID !== 1'b0) begin n_fail++; $display("FAIL single_valid_k1: got %b want 0", EVENT_VALID); end
    tick();
    n_checks++; if (AERIN_ACK !== 1'b1) begin n_fail++; $display("FAIL single_ack_k2: got %b want 1", AERIN_ACK); end
    n_checks++; if (EVENT_VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid_k2: got %b want 1", EVENT_VALID); end
    n_checks++; if (EVENT_ADDR !== addr_t'(3)) begin n_fail++; $display("FAIL single_addr: got %0d want 3", EVENT_ADDR); end
    n_checks++; if (FIFO_COUNT !== cnt_t'(1)) begin n_fail++; $display("FAIL single_count: got %0d want 1", FIFO_COUNT); end
    AERIN_REQ = 1'b0;
    tick();
    tick();
    n_checks++; if (AERIN_ACK !== 1'b1) begin n_fail++; $display("FAIL single_ack_hold: got %b want 1", AERIN_ACK); end
    tick();
    n_checks++; if (AERIN_ACK !== 1'b0) begin n_fail++; $display("FAIL single_ack_drop: got %b want 0", AERIN_ACK); end
    n_checks++; if (FIFO_COUNT !== cnt_t'(1)) begin n_fail++; $display("FAIL single_count_held: got %0d want 1", FIFO_COUNT); end
    EVENT_READY = 1'b1;
    tick();
    EVENT_READY = 1'b0;
    n_checks++; if (FIFO_COUNT !== cnt_t'(0)) begin n_fail++; $display("FAIL single_count_pop: got %0d want 0", FIFO_COUNT); end
    n_checks++; if (EVENT_VALID !== 1'b0) begin n_fail++; $display("FAIL single_valid_pop: got %b want 0", EVENT_VALID); end
    n_checks++; if (AERIN_RX_BUSY !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", AERIN_RX_BUSY); end
    // READY while empty must not underflow the count.
    EVENT_READY = 1'b1;
    tick();
    EVENT_READY = 1'b0;
    n_checks++; if (FIFO_COUNT !== cnt_t'(0)) begin n_fail++; $display("FAIL single_underflow: got %0d want 0", FIFO_COUNT); end
  endtask

  task automatic test_burst_backpressure();
    bit    ok;
    addr_t exp_order[4];
    exp_order[0] = addr_t'(2);
    exp_order[1] = addr_t'(3);
    exp_order[2] = addr_t'(4);
    exp_order[3] = addr_t'(0);
    EVENT_READY = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      do_event(addr_t'(i), ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL burst_handshake_%0d: got %b want 1", i, ok); end
    end
    n_checks++; if (FIFO_COUNT !== cnt_t'(4)) begin n_fail++; $display("FAIL burst_count_full: got %0d want 4", FIFO_COUNT); end
    AERIN_ADDR = addr_t'(0);
    AERIN_REQ  = 1'b1;
    repeat (10) tick();
    n_checks++; if (AERIN_ACK !== 1'b0) begin n_fail++; $display("FAIL burst_backpressure_ack: got %b want 0", AERIN_ACK); end
    n_checks++; if (FIFO_COUNT !== cnt_t'(4)) begin n_fail++; $display("FAIL burst_count_no_overflow: got %0d want 4", FIFO_COUNT); end
    n_checks++; if (EVENT_ADDR !== addr_t'(1)) begin n_fail++; $display("FAIL burst_head_first: got %0d want 1", EVENT_ADDR); end
    EVENT_READY = 1'b1;
    tick();
    EVENT_READY = 1'b0;
    // Pop edge alone must not admit the push; it follows one edge later.
    n_checks++; if (AERIN_ACK !== 1'b0) begin n_fail++; $display("FAIL burst_ack_same_edge: got %b want 0", AERIN_ACK); end
    n_checks++; if (FIFO_COUNT !== cnt_t'(3)) begin n_fail++; $display("FAIL burst_count_after_pop: got %0d want 3", FIFO_COUNT); end
    tick();
    n_checks++; if (AERIN_ACK !== 1'b1) begin n_fail++; $display("FAIL burst_ack_released: got %b want 1", AERIN_ACK); end
    n_checks++; if (FIFO_COUNT !== cnt_t'(4)) begin n_fail++; $display("FAIL burst_count_refill: got %0d want 4", FIFO_COUNT); end
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL burst_ack_low: got %b want 1", ok); end
    EVENT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (EVENT_VALID !== 1'b1 || EVENT_ADDR !== exp_order[i]) begin
        n_fail++; $display("FAIL burst_pop_%0d: got valid=%b addr=%0d want valid=1 addr=%0d", i, EVENT_VALID, EVENT_ADDR, exp_order[i]);
      end
      tick();
    end
    EVENT_READY = 1'b0;
    n_checks++; if (FIFO_COUNT !== cnt_t'(0)) begin n_fail++; $display("FAIL burst_drained: got %0d want 0", FIFO_COUNT); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_event(addr_t'(1), ok);
    do_event(addr_t'(2), ok);
    n_checks++; if (FIFO_COUNT !== cnt_t'(2)) begin n_fail++; $display("FAIL simul_count_pre: got %0d want 2", FIFO_COUNT); end
    AERIN_ADDR = addr_t'(3);
    AERIN_REQ  = 1'b1;
    tick();
    tick();
    EVENT_READY = 1'b1;
    tick();
    EVENT_READY = 1'b0;
    n_checks++; if (AERIN_ACK !== 1'b1) begin n_fail++; $display("FAIL simul_ack: got %b want 1", AERIN_ACK); end
    n_checks++; if (FIFO_COUNT !== cnt_t'(2)) begin n_fail++; $display("FAIL simul_count: got %0d want 2", FIFO_COUNT); end
    n_checks++; if (EVENT_ADDR !== addr_t'(2)) begin n_fail++; $display("FAIL simul_head: got %0d want 2", EVENT_ADDR); end
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, 20, ok);
    EVENT_READY = 1'b1;
    tick();
    n_checks++; if (EVENT_ADDR !== addr_t'(3)) begin n_fail++; $display("FAIL simul_tail: got %0d want 3", EVENT_ADDR); end
    tick();
    EVENT_READY = 1'b0;
    n_checks++; if (FIFO_COUNT !== cnt_t'(0)) begin n_fail++; $display("FAIL simul_drained: got %0d want 0", FIFO_COUNT); end
  endtask

  task automatic test_wraparound();
    bit ok;
    mon_q.delete();
    mon_en      = 1'b1;
    EVENT_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_event(addr_t'(i % 5), ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_handshake_%0d: got %b want 1", i, ok); end
    end
    repeat (2) tick();
    mon_en      = 1'b0;
    EVENT_READY = 1'b0;
    n_checks++; if (mon_q.size() != 10) begin n_fail++; $display("FAIL wrap_delivered: got %0d want 10", mon_q.size()); end
    for (int i = 0; i < 10 && i < mon_q.size(); i++) begin
      n_checks++; if (mon_q[i] !== addr_t'(i % 5)) begin n_fail++; $display("FAIL wrap_order_%0d: got %0d want %0d", i, mon_q[i], i % 5); end
    end
    n_checks++; if (FIFO_COUNT !== cnt_t'(0)) begin n_fail++; $display("FAIL wrap_count: got %0d want 0", FIFO_COUNT); end
  endtask

  task automatic test_reset_mid_handshake();
    bit ok;
    EVENT_READY = 1'b0;
    do_event(addr_t'(1), ok);
    AERIN_ADDR = addr_t'(2);
    AERIN_REQ  = 1'b1;
    wait_ack(1'b1, 20, ok);
    n_checks++; if (FIFO_COUNT !== cnt_t'(2) || ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got count=%0d ack_seen=%b want 2/1", FIFO_COUNT, ok); end
    #2 RST_N = 1'b0;
    #1;
    n_checks++; if (AERIN_ACK !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack: got %b want 0", AERIN_ACK); end
    n_checks++; if (EVENT_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", EVENT_VALID); end
    n_checks++; if (FIFO_COUNT !== cnt_t'(0)) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", FIFO_COUNT); end
    repeat (2) tick();
    RST_N = 1'b1;
    wait_ack(1'b1, 10, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_reack: got %b want 1", ok); end
    n_checks++; if (EVENT_ADDR !== addr_t'(2)) begin n_fail++; $display("FAIL rstmid_addr: got %0d want 2", EVENT_ADDR); end
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, 20, ok);
    repeat (10) tick();
    n_checks++; if (FIFO_COUNT !== cnt_t'(1)) begin n_fail++; $display("FAIL rstmid_once: got %0d want 1", FIFO_COUNT); end
    EVENT_READY = 1'b1;
    tick();
    EVENT_READY = 1'b0;
  endtask

`ifdef AER_RX_ADDR_CHECK_EN
  task automatic test_addr_check();
    bit ok;
    AERIN_ADDR = addr_t'(7);
    AERIN_REQ  = 1'b1;
    repeat (3) tick();
    n_checks++; if (AERIN_ACK !== 1'b1) begin n_fail++; $display("FAIL addrchk_ack: got %b want 1", AERIN_ACK); end
    n_checks++; if (ADDR_ERR !== 1'b1) begin n_fail++; $display("FAIL addrchk_err: got %b want 1", ADDR_ERR); end
    n_checks++; if (FIFO_COUNT !== cnt_t'(0)) begin n_fail++; $display("FAIL addrchk_count: got %0d want 0", FIFO_COUNT); end
    tick();
    n_checks++; if (ADDR_ERR !== 1'b0) begin n_fail++; $display("FAIL addrchk_err_pulse: got %b want 0", ADDR_ERR); end
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL addrchk_ack_low: got %b want 1", ok); end
    do_event(addr_t'(4), ok);
    n_checks++; if (FIFO_COUNT !== cnt_t'(1) || EVENT_ADDR !== addr_t'(4)) begin n_fail++; $display("FAIL addrchk_inrange: got count=%0d addr=%0d want 1/4", FIFO_COUNT, EVENT_ADDR); end
    EVENT_READY = 1'b1;
    tick();
    EVENT_READY = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_event();
    test_burst_backpressure();
    test_simultaneous();
    test_wraparound();
    test_reset_mid_handshake();
`ifdef AER_RX_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aer_receiver.md
Name: aer_receiver

Overview:
- Receiving end of the 4-phase AER REQ/ACK link driven by the AER transmitter (AERIN_ADDR / AERIN_REQ / AERIN_ACK).
- Synchronises the asynchronous REQ and captures the bundled address.
- Buffers captured events in a small FWFT FIFO and presents them to the SNN core on a valid/ready interface.
- Throttles the sender by withholding ACK while the buffer is full.

Parameters:
- IMAGE_SIZE, 5, number of input pixels/neurons addressed over the link.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), address MSB index; address width is IMAGE_SIZE_BITS+1.
- FIFO_DEPTH, 4, event buffer entries; power of two, >= 2.
- FIFO_PTR_BITS, $clog2(FIFO_DEPTH), FIFO pointer width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- AERIN_ADDR  in  IMAGE_SIZE_BITS+1  bundled address; stable while AERIN_REQ=1.
- AERIN_REQ  in  1  asynchronous request from the transmitter.
- AERIN_ACK  out  1  acknowledge to the transmitter; registered.
- EVENT_ADDR  out  IMAGE_SIZE_BITS+1  head-of-FIFO address.
- EVENT_VALID  out  1  FIFO not empty.
- EVENT_READY  in  1  core consumes the head entry when VALID&&READY.
- FIFO_COUNT  out  FIFO_PTR_BITS+1  occupancy, 0..FIFO_DEPTH.
- AERIN_RX_BUSY  out  1  state != IDLE or FIFO not empty.

Behaviour:
- Reset (RST_N=0, async): AERIN_ACK=0, FIFO empty, EVENT_VALID=0, EVENT_ADDR=0, FIFO_COUNT=0, AERIN_RX_BUSY=0, state=IDLE, sync flops=0.
- Synchroniser: REQ_sync_int <= AERIN_REQ; REQ_sync <= REQ_sync_int. AERIN_ADDR is sampled directly, because it has been stable for >=2 cycles when REQ_sync=1.
- FSM states: IDLE and ACK_HI.
- IDLE, REQ_sync=1 and FIFO not full:
  - push AERIN_ADDR into the FIFO;
  - AERIN_ACK <= 1;
  - go to ACK_HI.
- IDLE, REQ_sync=1 and FIFO full: stay in IDLE with ACK=0 (backpressure). The sender holds REQ and ADDR.
- ACK_HI, REQ_sync=0: AERIN_ACK <= 0, go to IDLE. Otherwise hold ACK=1.
- Latency: REQ rising before edge k gives ACK=1 after edge k+2 and EVENT_VALID=1 after edge k+2 (same edge as the push) when the FIFO was empty.
- Exactly one push per 4-phase cycle. No new capture until REQ_sync has been seen low.
- FIFO: first-word-fall-through; EVENT_ADDR = mem[rd_ptr]; pop on EVENT_VALID&&EVENT_READY.
- Simultaneous push and pop: both happen and FIFO_COUNT is unchanged.
- Full test uses the registered count only. A same-cycle pop does not free space for a push; the push occurs one cycle later.
- Pointers wrap modulo FIFO_DEPTH. FIFO_COUNT never exceeds FIFO_DEPTH and never underflows. READY while empty is ignored.
- Reset mid-handshake: ACK drops immediately and buffered events are lost. If REQ is still high after reset release, the event is re-captured (a duplicate is permitted and documented).
- EVENT_ADDR is don't-care while EVENT_VALID=0.

Optional Feature:
- AER_RX_ADDR_CHECK_EN defined:
  - addresses >= IMAGE_SIZE are still acknowledged normally but are not pushed;
  - an extra output ADDR_ERR (1 bit) pulses high for one cycle on the capturing edge;
  - full backpressure does not apply to dropped addresses.
- Undefined: no ADDR_ERR port; every address is pushed.

Decomposition:
- Shared package aer_pkg holds:
  - the FSM state enum (RX_IDLE, RX_ACK_HI);
  - the address-width helper;
  - the default FIFO_DEPTH constant.
- Natural sub-module: aer_event_fifo (sync FWFT FIFO with count/full/empty). Synchroniser and FSM stay in aer_receiver.

Test Plan:
- Single event: ADDR=3, raise REQ. Expect:
  - ACK=1 two edges after REQ_sync sampling;
  - EVENT_VALID=1 with EVENT_ADDR=3;
  - drop REQ, ACK returns to 0 two edges later;
  - FIFO_COUNT=1 until READY pops it.
- Burst with READY=0: send 4 events (1,2,3,4) with FIFO_DEPTH=4. Expect:
  - FIFO_COUNT=4;
  - 5th REQ (addr 0) gets no ACK;
  - one READY pulse lets addr 0 be acked next;
  - pop order is 1,2,3,4,0.
- Simultaneous push/pop: FIFO_COUNT=2, READY=1 on the capture edge. Expect FIFO_COUNT stays 2 and the correct head advances.
- Wrap-around: stream 10 events (addrs 0..4 repeated) with READY=1 each cycle. Expect in-order delivery and pointers wrapping without loss.
- Reset mid-handshake: assert RST_N=0 while ACK=1 and the FIFO holds 2 entries. Expect:
  - ACK=0, VALID=0, COUNT=0 asynchronously;
  - REQ still high after release is re-acked once.
- With AER_RX_ADDR_CHECK_EN, ADDR=7 (IMAGE_SIZE=5). Expect ACK handshake completes, ADDR_ERR=1 for one cycle, FIFO_COUNT unchanged.
